// File: rtl/port_mux_ctrl.sv
// Port A pin-function controller: key-protected FUNC register with drain-gapped switching.
// Bus is zero-wait except a FUNC write during a switch (ready low); pad outputs lag inputs one clock.
module port_mux_ctrl #(
  parameter int          CHIP_PORT_A_WIDTH = 16,
  parameter int          UART_TX_PIN       = 0,
  parameter int          UART_RX_PIN       = 1,
  parameter int          SWITCH_GAP        = 4,
  parameter logic [31:0] UNLOCK_KEY        = 32'hA5C3_0F1E,
  parameter int          UNLOCK_TIMEOUT    = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         pmux_sel,
  input  logic                         pmux_write,
  input  logic [3:0]                   pmux_addr,
  input  logic [31:0]                  pmux_wdata,
  output logic [31:0]                  pmux_rdata,
  output logic                         pmux_ready,
  input  logic [CHIP_PORT_A_WIDTH-1:0] gpio_pad_out,
  output logic [CHIP_PORT_A_WIDTH-1:0] pad_gpio_in,
  input  logic                         uart_pad_tx,
  output logic                         pad_uart_rx,
  input  logic [CHIP_PORT_A_WIDTH-1:0] pad_pmux_din,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_dout,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_oe,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_ie
);
  localparam int W  = CHIP_PORT_A_WIDTH;
  localparam int GW = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
  localparam int TW = $clog2(UNLOCK_TIMEOUT + 1);

  typedef enum logic {LOCKED, UNLOCKED} lock_state_t;
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} sw_state_t;

  lock_state_t   lock_state;
  sw_state_t     sw_state;
  logic [TW-1:0] lock_cnt;
  logic [GW-1:0] gap_cnt;
  logic [W-1:0]  func_act;
  logic [W-1:0]  func_pend;
  logic [W-1:0]  gpio_oe;
  logic          key_err;
  logic          lock_err;

  logic [1:0]    reg_idx;
  logic          busy;
  logic          unlocked;
  logic          func_req;
  logic          func_wr;
  logic          func_ok;
  logic          oe_wr;
  logic          key_wr;
  logic          key_ok;
  logic          status_rd;
  logic          unused_bits;

  assign reg_idx     = pmux_addr[3:2];
  assign busy        = (sw_state != IDLE);
  assign unlocked    = (lock_state == UNLOCKED);
  assign func_req    = pmux_sel & pmux_write & (reg_idx == 2'd0);
  assign func_wr     = func_req & ~busy;
  assign func_ok     = func_wr & unlocked;
  assign oe_wr       = pmux_sel & pmux_write & (reg_idx == 2'd1);
  assign key_wr      = pmux_sel & pmux_write & (reg_idx == 2'd2);
  assign key_ok      = key_wr & (pmux_wdata == UNLOCK_KEY);
  assign status_rd   = pmux_sel & ~pmux_write & (reg_idx == 2'd3);
  assign pmux_ready  = ~(func_req & busy);
  assign unused_bits = ^{pmux_addr[1:0], pmux_wdata};

  always_comb begin
    pmux_rdata = '0;
    if (pmux_sel && !pmux_write) begin
      case (reg_idx)
        2'd0:    pmux_rdata[W-1:0] = func_act;
        2'd1:    pmux_rdata[W-1:0] = gpio_oe;
        2'd3:    pmux_rdata[3:0]   = {lock_err, key_err, busy, unlocked};
        default: pmux_rdata        = '0;
      endcase
    end
  end

  // Any FUNC write that gets through, a bad key, or expiry closes the window.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lock_state <= LOCKED;
      lock_cnt   <= '0;
    end else begin
      case (lock_state)
        LOCKED: begin
          if (key_ok) begin
            lock_state <= UNLOCKED;
            lock_cnt   <= TW'(UNLOCK_TIMEOUT);
          end
        end
        UNLOCKED: begin
          if (func_wr || (key_wr && !key_ok) || (!key_wr && lock_cnt <= TW'(1))) begin
            lock_state <= LOCKED;
            lock_cnt   <= '0;
          end else if (key_ok) begin
            lock_cnt   <= TW'(UNLOCK_TIMEOUT);
          end else begin
            lock_cnt   <= lock_cnt - TW'(1);
          end
        end
      endcase
    end
  end

  // Sticky errors; a new error in the same cycle as a STATUS read survives it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      key_err  <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      if (key_wr && !key_ok)     key_err <= 1'b1;
      else if (status_rd)        key_err <= 1'b0;
      if (func_wr && !unlocked)  lock_err <= 1'b1;
      else if (status_rd)        lock_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sw_state  <= IDLE;
      gap_cnt   <= '0;
      func_pend <= '0;
      func_act  <= '0;
      gpio_oe   <= '0;
    end else begin
      if (oe_wr) gpio_oe <= pmux_wdata[W-1:0];
      case (sw_state)
        IDLE: begin
          if (func_ok && (pmux_wdata[W-1:0] != func_act)) begin
            func_pend <= pmux_wdata[W-1:0];
            gap_cnt   <= GW'(SWITCH_GAP - 1);
            sw_state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (gap_cnt == '0) sw_state <= APPLY;
          else               gap_cnt  <= gap_cnt - GW'(1);
        end
        APPLY: begin
          func_act <= func_pend;
          sw_state <= IDLE;
        end
        default: sw_state <= IDLE;
      endcase
    end
  end

  // Pins whose owner is changing stay fully released until the new mapping is active.
  logic [W-1:0] gate;
  logic [W-1:0] nx_dout;
  logic [W-1:0] nx_oe;
  logic [W-1:0] nx_ie;
  logic         nx_rx;

  assign gate  = busy ? (func_pend ^ func_act) : '0;
  assign nx_rx = (func_act[UART_RX_PIN] && !gate[UART_RX_PIN]) ? pad_pmux_din[UART_RX_PIN] : 1'b1;

  always_comb begin
    nx_dout = '0;
    nx_oe   = '0;
    nx_ie   = '0;
    for (int i = 0; i < W; i++) begin
      if (!gate[i]) begin
        if (!func_act[i]) begin
          nx_dout[i] = gpio_pad_out[i];
          nx_oe[i]   = gpio_oe[i];
          nx_ie[i]   = 1'b1;
        end else if (i == UART_TX_PIN) begin
          nx_dout[i] = uart_pad_tx;
          nx_oe[i]   = 1'b1;
        end else if (i == UART_RX_PIN) begin
          nx_ie[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pmux_pad_dout <= '0;
      pmux_pad_oe   <= '0;
      pmux_pad_ie   <= '1;
      pad_gpio_in   <= '0;
      pad_uart_rx   <= 1'b1;
    end else begin
      pmux_pad_dout <= nx_dout;
      pmux_pad_oe   <= nx_oe;
      pmux_pad_ie   <= nx_ie;
      pad_gpio_in   <= pad_pmux_din & nx_ie;
      pad_uart_rx   <= nx_rx;
    end
  end

endmodule

// File: tb/tb_port_mux_ctrl.sv
// Scoreboarded bench for port_mux_ctrl: a reference model predicts bus responses and pad state per edge.
module tb_port_mux_ctrl;
  localparam int          W   = 16;
  localparam int          TXP = 0;
  localparam int          RXP = 1;
  localparam int          G   = 4;
  localparam logic [31:0] KEY = 32'hA5C3_0F1E;
  localparam int          T   = 64;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          pmux_sel;
  logic          pmux_write;
  logic [3:0]    pmux_addr;
  logic [31:0]   pmux_wdata;
  logic [31:0]   pmux_rdata;
  logic          pmux_ready;
  logic [W-1:0]  gpio_pad_out;
  logic [W-1:0]  pad_gpio_in;
  logic          uart_pad_tx;
  logic          pad_uart_rx;
  logic [W-1:0]  pad_pmux_din;
  logic [W-1:0]  pmux_pad_dout;
  logic [W-1:0]  pmux_pad_oe;
  logic [W-1:0]  pmux_pad_ie;

  always #5 clk_in = ~clk_in;

  port_mux_ctrl #(
    .CHIP_PORT_A_WIDTH(W), .UART_TX_PIN(TXP), .UART_RX_PIN(RXP),
    .SWITCH_GAP(G), .UNLOCK_KEY(KEY), .UNLOCK_TIMEOUT(T)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .pmux_sel(pmux_sel), .pmux_write(pmux_write), .pmux_addr(pmux_addr),
    .pmux_wdata(pmux_wdata), .pmux_rdata(pmux_rdata), .pmux_ready(pmux_ready),
    .gpio_pad_out(gpio_pad_out), .pad_gpio_in(pad_gpio_in),
    .uart_pad_tx(uart_pad_tx), .pad_uart_rx(pad_uart_rx),
    .pad_pmux_din(pad_pmux_din), .pmux_pad_dout(pmux_pad_dout),
    .pmux_pad_oe(pmux_pad_oe), .pmux_pad_ie(pmux_pad_ie)
  );

  typedef struct { logic [W-1:0] dout; logic [W-1:0] oe; logic [W-1:0] ie; logic [W-1:0] gin; logic rx; } pad_exp_t;
  typedef struct { logic ready; logic chk; logic [31:0] rdata; } bus_exp_t;

  pad_exp_t pad_q[$];
  bus_exp_t bus_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: edge-numbered events rather than state machines.
  int           ecount = 0;      // index of the last clock edge applied to the model
  logic [W-1:0] m_func, m_oe, m_pend;
  bit           m_unl, m_sw, m_kerr, m_lerr;
  int           m_deadline;      // last edge at which a FUNC write is still honoured
  int           m_swstart;       // edge at which the running switch was accepted

  function automatic bus_exp_t bus_expect(input logic w, input logic [3:0] a);
    bus_exp_t   b;
    logic [1:0] idx;
    idx     = a[3:2];
    b.ready = !(w && idx == 2'd0 && m_sw);
    b.chk   = !w;
    b.rdata = 32'd0;
    if (!w) begin
      case (idx)
        2'd0: b.rdata = 32'(m_func);
        2'd1: b.rdata = 32'(m_oe);
        2'd3: b.rdata = {28'd0, m_lerr, m_kerr, m_sw, (m_unl && ecount < m_deadline)};
        default: b.rdata = 32'd0;
      endcase
    end
    return b;
  endfunction

  task automatic model_step();
    pad_exp_t     p;
    int           e;
    logic [W-1:0] gate;
    logic [1:0]   idx;
    bit           ready;
    e = ecount + 1;
    if (rst_in) begin
      m_func = '0; m_oe = '0; m_pend = '0;
      m_unl = 0; m_sw = 0; m_kerr = 0; m_lerr = 0; m_deadline = -1; m_swstart = 0;
      p.dout = '0; p.oe = '0; p.ie = '1; p.gin = '0; p.rx = 1'b1;
    end else begin
      gate   = m_sw ? (m_pend ^ m_func) : '0;
      p.dout = '0; p.oe = '0; p.ie = '0;
      for (int i = 0; i < W; i++) begin
        if (gate[i]) continue;
        if (m_func[i] == 1'b0) begin
          p.dout[i] = gpio_pad_out[i]; p.oe[i] = m_oe[i]; p.ie[i] = 1'b1;
        end else if (i == TXP) begin
          p.dout[i] = uart_pad_tx; p.oe[i] = 1'b1;
        end else if (i == RXP) begin
          p.ie[i] = 1'b1;
        end
      end
      p.gin = pad_pmux_din & p.ie;
      p.rx  = (m_func[RXP] && !gate[RXP]) ? pad_pmux_din[RXP] : 1'b1;

      idx   = pmux_addr[3:2];
      ready = !(pmux_write && idx == 2'd0 && m_sw);
      if (pmux_sel && pmux_write && ready) begin
        case (idx)
          2'd0: begin
            if (m_unl && e <= m_deadline) begin
              m_unl = 0;
              if (pmux_wdata[W-1:0] != m_func) begin
                m_sw = 1; m_swstart = e; m_pend = pmux_wdata[W-1:0];
              end
            end else begin
              m_lerr = 1;
            end
          end
          2'd1: m_oe = pmux_wdata[W-1:0];
          2'd2: begin
            if (pmux_wdata == KEY) begin m_unl = 1; m_deadline = e + T; end
            else begin m_kerr = 1; m_unl = 0; end
          end
          default: ;
        endcase
      end
      if (pmux_sel && !pmux_write && idx == 2'd3) begin
        m_kerr = 0; m_lerr = 0;
      end
      if (m_sw && e == m_swstart + G + 1) begin
        m_func = m_pend; m_sw = 0;
      end
    end
    pad_q.push_back(p);
    ecount = e;
  endtask

  // One bus cycle with fresh random pad-side inputs; returns the predicted ready.
  task automatic cyc(input bit s, input bit w, input logic [3:0] a, input logic [31:0] d, output bit rdy);
    bus_exp_t b;
    pmux_sel     = s;
    pmux_write   = w;
    pmux_addr    = a;
    pmux_wdata   = d;
    gpio_pad_out = W'($urandom);
    uart_pad_tx  = 1'($urandom);
    pad_pmux_din = W'($urandom);
    b   = bus_expect(w, a);
    rdy = b.ready;
    if (s) bus_q.push_back(b);
    @(posedge clk_in);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    bit r;
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 32'd0, r);
  endtask

  task automatic rd(input logic [3:0] a);
    bit r;
    cyc(1, 0, a, 32'($urandom), r);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bit r;
    int n;
    n = 0;
    forever begin
      cyc(1, 1, a, d, r);
      if (r) break;
      n++;
      if (n > 3 * G + 10) begin
        total++; bad++;
        $display("FAIL stall_bound addr=%h waited=%0d cycles, limit=%0d", a, n, 3 * G + 10);
        break;
      end
    end
  endtask

  always @(negedge clk_in) begin : monitor
    pad_exp_t p;
    bus_exp_t b;
    if (pad_q.size() > 0) begin
      p = pad_q.pop_front();
      total++;
      if ({pmux_pad_dout, pmux_pad_oe, pmux_pad_ie, pad_gpio_in, pad_uart_rx} !==
          {p.dout, p.oe, p.ie, p.gin, p.rx}) begin
        bad++;
        $display("FAIL pads edge=%0d dout=%h/%h oe=%h/%h ie=%h/%h gin=%h/%h rx=%b/%b (got/exp)",
                 ecount, pmux_pad_dout, p.dout, pmux_pad_oe, p.oe, pmux_pad_ie, p.ie,
                 pad_gpio_in, p.gin, pad_uart_rx, p.rx);
      end
    end
    if (pmux_sel === 1'b1) begin
      total++;
      if (bus_q.size() == 0) begin
        bad++;
        $display("FAIL bus_unexpected edge=%0d got ready=%b, expected no access", ecount, pmux_ready);
      end else begin
        b = bus_q.pop_front();
        if (pmux_ready !== b.ready || (b.chk && pmux_rdata !== b.rdata)) begin
          bad++;
          $display("FAIL bus edge=%0d addr=%h wr=%b ready=%b/%b rdata=%h/%h (got/exp)",
                   ecount, pmux_addr, pmux_write, pmux_ready, b.ready, pmux_rdata, b.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] nf;
    logic [3:0]   a;
    int           r;
    rst_in = 1'b1;
    idle(3);
    rst_in = 1'b0;

    rd(4'hC);                       // STATUS clear after reset
    wr(4'h4, 32'h0000_00F0);
    idle(2);
    rd(4'h4);
    wr(4'h0, 32'h0000_0003);        // locked: discarded, lock_err
    rd(4'h0);
    rd(4'hC);
    rd(4'hC);
    wr(4'h8, KEY);
    rd(4'hC);
    wr(4'h0, 32'hFFFF_0003);        // upper bits ignored
    wr(4'h4, 32'h0000_0001);
    rd(4'hC);
    wr(4'h0, 32'h0000_0000);        // stalls through the drain, then lock_err
    rd(4'hC);
    idle(3);
    rd(4'h0);
    wr(4'h8, KEY);                  // last honoured edge
    idle(T - 1);
    wr(4'h0, 32'h0000_0000);
    idle(G + 3);
    rd(4'hC);
    wr(4'h8, KEY);                  // one edge too late
    idle(T);
    wr(4'h0, 32'h0000_0002);
    rd(4'hC);
    wr(4'h8, 32'h1234_5678);        // wrong key
    rd(4'hC);
    rd(4'hC);
    wr(4'h8, KEY);
    wr(4'h0, 32'h0000_0003);
    idle(2);
    rst_in = 1'b1;                  // reset mid-switch drops the pending value
    idle(1);
    rst_in = 1'b0;
    idle(G + 3);
    rd(4'h0);

    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      a = {2'd0, 2'($urandom_range(0, 3))};
      if (r < 15) begin
        wr(a | 4'h8, ($urandom_range(0, 3) == 0) ? $urandom : KEY);
      end else if (r < 35) begin
        if ($urandom_range(0, 2) == 0) nf = W'($urandom);
        else                           nf = m_func ^ (W'(1) << $urandom_range(0, W - 1));
        wr(a, {16'($urandom), nf});
      end else if (r < 50) begin
        wr(a | 4'h4, $urandom);
      end else if (r < 75) begin
        rd(a | 4'({$urandom_range(0, 3), 2'b00}));
      end else if (r < 77) begin
        idle($urandom_range(T - 8, T + 6));
      end else if (r < 78) begin
        rst_in = 1'b1;
        idle($urandom_range(1, 2));
        rst_in = 1'b0;
      end else begin
        idle(1);
      end
    end

    idle(3);
    @(negedge clk_in);
    #1;
    total++;
    if (bus_q.size() != 0 || pad_q.size() != 0) begin
      bad++;
      $display("FAIL leftover bus_q=%0d pad_q=%0d, expected 0/0", bus_q.size(), pad_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
